// File: rtl/swarm_integrator_if.sv
// Load, control and result-stream bundle for swarm_integrator.
interface swarm_integrator_if #(
   parameter int N_BOTS = 4,
   parameter int W      = 16
);
   localparam int IW = $clog2(N_BOTS);

   logic          load_valid;
   logic          load_ready;
   logic [IW-1:0] load_idx;
   logic [W-1:0]  load_x;
   logic [W-1:0]  load_y;
   logic [W-1:0]  load_vx;
   logic [W-1:0]  load_vy;
   logic          start;
   logic [W-1:0]  dt;
   logic [W-1:0]  ax;
   logic [W-1:0]  ay;
   logic [W-1:0]  radius;
   logic          busy;
   logic          out_valid;
   logic          out_ready;
   logic [IW-1:0] out_idx;
   logic [W-1:0]  out_x;
   logic [W-1:0]  out_y;
   logic [W-1:0]  out_vx;
   logic [W-1:0]  out_vy;
   logic          out_coll;
   logic          done;
   logic [7:0]    coll_count;

   modport master (
      output load_valid, load_idx, load_x, load_y, load_vx, load_vy,
      output start, dt, ax, ay, radius, out_ready,
      input  load_ready, busy, out_valid, out_idx,
      input  out_x, out_y, out_vx, out_vy, out_coll, done, coll_count
   );

   modport slave (
      input  load_valid, load_idx, load_x, load_y, load_vx, load_vy,
      input  start, dt, ax, ay, radius, out_ready,
      output load_ready, busy, out_valid, out_idx,
      output out_x, out_y, out_vx, out_vy, out_coll, done, coll_count
   );
endinterface

// File: rtl/swarm_integrator.sv
// N-bot Euler step, pairwise velocity-swap collisions, then in-order result stream.
// SWARM_WALL_BOUNCE_EN adds a per-bot arena wall bounce pass after collisions.
module swarm_integrator #(
   parameter int N_BOTS = 4,
   parameter int W      = 16,
   parameter int FRAC   = 11
`ifdef SWARM_WALL_BOUNCE_EN
   ,
   parameter logic signed [W-1:0] ARENA_MAX = 'h7800
`endif
) (
   input logic               clock,
   input logic               reset,
   swarm_integrator_if.slave bus
);
   localparam int IW = $clog2(N_BOTS);
   localparam logic [IW-1:0] LAST    = IW'(N_BOTS - 1);
   localparam logic [IW-1:0] PI_LAST = IW'(N_BOTS - 2);

   typedef logic signed [W-1:0] word_t;
   typedef logic signed [2*W:0] wide_t;

   localparam word_t MAX_W = {1'b0, {(W-1){1'b1}}};
   localparam word_t MIN_W = {1'b1, {(W-1){1'b0}}};
   localparam wide_t SMAX  = {{(W+1){1'b0}}, MAX_W};
   localparam wide_t SMIN  = {{(W+1){1'b1}}, MIN_W};

   typedef enum logic [2:0] {
      IDLE,
      UPDATE,
      COLLIDE,
`ifdef SWARM_WALL_BOUNCE_EN
      WALL,
`endif
      EMIT,
      DONE
   } state_t;

   state_t        state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [IW-1:0] pj_q, pj_d;
   word_t         x_q [N_BOTS];
   word_t         x_d [N_BOTS];
   word_t         y_q [N_BOTS];
   word_t         y_d [N_BOTS];
   word_t         vx_q [N_BOTS];
   word_t         vx_d [N_BOTS];
   word_t         vy_q [N_BOTS];
   word_t         vy_d [N_BOTS];
   logic [N_BOTS-1:0] coll_q, coll_d;
   logic [7:0]    cnt_q, cnt_d;
   word_t         dt_q, dt_d;
   word_t         ax_q, ax_d;
   word_t         ay_q, ay_d;
   logic [W-1:0]  rad_q, rad_d;

   function automatic word_t sat(input wide_t v);
      if (v > SMAX) return MAX_W;
      if (v < SMIN) return MIN_W;
      return v[W-1:0];
   endfunction

   // base + floor(rate*t / 2^FRAC), products kept at full 2W width
   function automatic word_t upd(input word_t base, input word_t rate,
                                 input word_t t);
      logic signed [2*W-1:0] r2;
      logic signed [2*W-1:0] t2;
      logic signed [2*W-1:0] prod;
      wide_t                 sum;
      r2   = {{W{rate[W-1]}}, rate};
      t2   = {{W{t[W-1]}}, t};
      prod = (r2 * t2) >>> FRAC;
      sum  = {{(W+1){base[W-1]}}, base} + {prod[2*W-1], prod};
      return sat(sum);
   endfunction

`ifdef SWARM_WALL_BOUNCE_EN
   function automatic word_t neg(input word_t v);
      return (v == MIN_W) ? MAX_W : -v;
   endfunction
`endif

   word_t nvx, nvy;
   assign nvx = upd(vx_q[idx_q], ax_q, dt_q);
   assign nvy = upd(vy_q[idx_q], ay_q, dt_q);

   logic signed [W:0]     dx, dy;
   logic signed [2*W+1:0] dxe, dye, sqx, sqy;
   logic [2*W+2:0]        re, d2, r2;
   logic                  hit;

   assign dx  = {x_q[idx_q][W-1], x_q[idx_q]} - {x_q[pj_q][W-1], x_q[pj_q]};
   assign dy  = {y_q[idx_q][W-1], y_q[idx_q]} - {y_q[pj_q][W-1], y_q[pj_q]};
   assign dxe = {{(W+1){dx[W]}}, dx};
   assign dye = {{(W+1){dy[W]}}, dy};
   assign sqx = dxe * dxe;
   assign sqy = dye * dye;
   assign re  = {{(W+3){1'b0}}, rad_q};
   assign d2  = {1'b0, sqx} + {1'b0, sqy};
   assign r2  = re * re;
   assign hit = d2 < r2;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      pj_d    = pj_q;
      x_d     = x_q;
      y_d     = y_q;
      vx_d    = vx_q;
      vy_d    = vy_q;
      coll_d  = coll_q;
      cnt_d   = cnt_q;
      dt_d    = dt_q;
      ax_d    = ax_q;
      ay_d    = ay_q;
      rad_d   = rad_q;
      unique case (state_q)
         IDLE: begin
            if (bus.load_valid && (int'(bus.load_idx) < N_BOTS)) begin
               x_d[bus.load_idx]  = bus.load_x;
               y_d[bus.load_idx]  = bus.load_y;
               vx_d[bus.load_idx] = bus.load_vx;
               vy_d[bus.load_idx] = bus.load_vy;
            end
            if (bus.start) begin
               dt_d    = bus.dt;
               ax_d    = bus.ax;
               ay_d    = bus.ay;
               rad_d   = bus.radius;
               coll_d  = '0;
               cnt_d   = '0;
               idx_d   = '0;
               state_d = UPDATE;
            end
         end
         UPDATE: begin
            vx_d[idx_q] = nvx;
            vy_d[idx_q] = nvy;
            x_d[idx_q]  = upd(x_q[idx_q], nvx, dt_q);
            y_d[idx_q]  = upd(y_q[idx_q], nvy, dt_q);
            if (idx_q == LAST) begin
               idx_d   = '0;
               pj_d    = IW'(1);
               state_d = COLLIDE;
            end else begin
               idx_d = idx_q + IW'(1);
            end
         end
         COLLIDE: begin
            if (hit) begin
               vx_d[idx_q]  = vx_q[pj_q];
               vy_d[idx_q]  = vy_q[pj_q];
               vx_d[pj_q]   = vx_q[idx_q];
               vy_d[pj_q]   = vy_q[idx_q];
               coll_d[idx_q] = 1'b1;
               coll_d[pj_q]  = 1'b1;
               if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
            end
            if (pj_q == LAST) begin
               if (idx_q == PI_LAST) begin
                  idx_d = '0;
`ifdef SWARM_WALL_BOUNCE_EN
                  state_d = WALL;
`else
                  state_d = EMIT;
`endif
               end else begin
                  idx_d = idx_q + IW'(1);
                  pj_d  = idx_q + IW'(2);
               end
            end else begin
               pj_d = pj_q + IW'(1);
            end
         end
`ifdef SWARM_WALL_BOUNCE_EN
         WALL: begin
            if (x_q[idx_q] < 0) begin
               x_d[idx_q]  = '0;
               vx_d[idx_q] = neg(vx_q[idx_q]);
            end else if (x_q[idx_q] > ARENA_MAX) begin
               x_d[idx_q]  = ARENA_MAX;
               vx_d[idx_q] = neg(vx_q[idx_q]);
            end
            if (y_q[idx_q] < 0) begin
               y_d[idx_q]  = '0;
               vy_d[idx_q] = neg(vy_q[idx_q]);
            end else if (y_q[idx_q] > ARENA_MAX) begin
               y_d[idx_q]  = ARENA_MAX;
               vy_d[idx_q] = neg(vy_q[idx_q]);
            end
            if (idx_q == LAST) begin
               idx_d   = '0;
               state_d = EMIT;
            end else begin
               idx_d = idx_q + IW'(1);
            end
         end
`endif
         EMIT: begin
            if (bus.out_ready) begin
               if (idx_q == LAST) state_d = DONE;
               else idx_d = idx_q + IW'(1);
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         idx_q   <= '0;
         pj_q    <= '0;
         x_q     <= '{default: '0};
         y_q     <= '{default: '0};
         vx_q    <= '{default: '0};
         vy_q    <= '{default: '0};
         coll_q  <= '0;
         cnt_q   <= '0;
         dt_q    <= '0;
         ax_q    <= '0;
         ay_q    <= '0;
         rad_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         pj_q    <= pj_d;
         x_q     <= x_d;
         y_q     <= y_d;
         vx_q    <= vx_d;
         vy_q    <= vy_d;
         coll_q  <= coll_d;
         cnt_q   <= cnt_d;
         dt_q    <= dt_d;
         ax_q    <= ax_d;
         ay_q    <= ay_d;
         rad_q   <= rad_d;
      end
   end

   logic emit;
   assign emit = (state_q == EMIT);

   assign bus.load_ready = (state_q == IDLE);
   assign bus.busy       = !(state_q inside {IDLE, DONE});
   assign bus.done       = (state_q == DONE);
   assign bus.out_valid  = emit;
   assign bus.out_idx    = emit ? idx_q : '0;
   assign bus.out_x      = emit ? x_q[idx_q] : '0;
   assign bus.out_y      = emit ? y_q[idx_q] : '0;
   assign bus.out_vx     = emit ? vx_q[idx_q] : '0;
   assign bus.out_vy     = emit ? vy_q[idx_q] : '0;
   assign bus.out_coll   = emit ? coll_q[idx_q] : 1'b0;
   assign bus.coll_count = cnt_q;
endmodule

// File: tb/tb_swarm_integrator.sv
// Directed bench for swarm_integrator with hand-computed expectations.
module tb_swarm_integrator;
   localparam int N = 4;
   localparam int W = 16;
`ifdef SWARM_WALL_BOUNCE_EN
   localparam int WX = N;
`else
   localparam int WX = 0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail = 0;

   logic [W-1:0] rx [N];
   logic [W-1:0] ry [N];
   logic [W-1:0] rvx [N];
   logic [W-1:0] rvy [N];
   logic         rc [N];
   int           ridx [N];
   int           done_cyc;
   int           first_cyc;
   int           nb;
   logic         held_ok;
   logic         busy_ok;
   logic         seen_done;
   logic [4*W-1:0] held;

   swarm_integrator_if #(.N_BOTS(N), .W(W)) bus ();

   swarm_integrator #(.N_BOTS(N), .W(W), .FRAC(11)) dut (
      .clock(clk),
      .reset(rst),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic load(input int i, input logic [W-1:0] x, y, vx, vy);
      @(negedge clk);
      bus.load_valid = 1'b1;
      bus.load_idx   = 2'(i);
      bus.load_x     = x;
      bus.load_y     = y;
      bus.load_vx    = vx;
      bus.load_vy    = vy;
      @(negedge clk);
      bus.load_valid = 1'b0;
   endtask

   task automatic chk_bot(input int i, input logic [W-1:0] x, y, vx, vy,
                          input logic c);
      chk($sformatf("b%0d_idx", i), 32'(ridx[i]), 32'(i));
      chk($sformatf("b%0d_x", i), 32'(rx[i]), 32'(x));
      chk($sformatf("b%0d_y", i), 32'(ry[i]), 32'(y));
      chk($sformatf("b%0d_vx", i), 32'(rvx[i]), 32'(vx));
      chk($sformatf("b%0d_vy", i), 32'(rvy[i]), 32'(vy));
      chk($sformatf("b%0d_coll", i), 32'(rc[i]), 32'(c));
   endtask

   // Called at a negedge with the DUT idle; leaves it idle again.
   task automatic do_step(input logic [W-1:0] t, a_x, a_y, r,
                          input int sb, input int sn, input bit inj);
      int stall;
      logic [4*W-1:0] beat;
      bus.dt        = t;
      bus.ax        = a_x;
      bus.ay        = a_y;
      bus.radius    = r;
      bus.start     = 1'b1;
      bus.out_ready = 1'b1;
      done_cyc  = -1;
      first_cyc = -1;
      nb        = 0;
      stall     = 0;
      held_ok   = 1'b1;
      busy_ok   = 1'b1;
      for (int c = 1; c <= 300 && done_cyc < 0; c++) begin
         @(negedge clk);
         bus.start      = 1'b0;
         bus.load_valid = 1'b0;
         if (inj && c == 1) begin
            chk("load_ready_busy", 32'(bus.load_ready), 32'd0);
            bus.load_valid = 1'b1;
            bus.load_idx   = '0;
            bus.load_x     = 16'h1234;
            bus.load_vx    = 16'h4321;
            bus.start      = 1'b1;
            bus.dt         = 16'h7FFF;
            bus.ax         = 16'h7FFF;
            bus.radius     = 16'hFFFF;
         end
         if (bus.done) begin
            done_cyc = c;
            if (bus.busy) busy_ok = 1'b0;
         end else if (!bus.busy) begin
            busy_ok = 1'b0;
         end
         beat = {bus.out_x, bus.out_y, bus.out_vx, bus.out_vy};
         if (bus.out_valid) begin
            if (first_cyc < 0) first_cyc = c;
            if (nb == sb && stall < sn) begin
               if (stall == 0) held = beat;
               else if (beat !== held) held_ok = 1'b0;
               stall++;
               bus.out_ready = 1'b0;
            end else begin
               if (stall > 0 && nb == sb && beat !== held) held_ok = 1'b0;
               bus.out_ready = 1'b1;
               if (nb < N) begin
                  rx[nb]   = bus.out_x;
                  ry[nb]   = bus.out_y;
                  rvx[nb]  = bus.out_vx;
                  rvy[nb]  = bus.out_vy;
                  rc[nb]   = bus.out_coll;
                  ridx[nb] = int'(bus.out_idx);
               end
               nb++;
            end
         end else begin
            bus.out_ready = 1'b1;
         end
      end
      chk("done_seen", 32'(done_cyc >= 0), 32'd1);
      chk("beats", 32'(nb), 32'(N));
      chk("busy_window", 32'(busy_ok), 32'd1);
      @(negedge clk);
      bus.load_valid = 1'b0;
      bus.start      = 1'b0;
   endtask

   initial begin
      bus.load_valid = 1'b0;
      bus.load_idx   = '0;
      bus.load_x     = '0;
      bus.load_y     = '0;
      bus.load_vx    = '0;
      bus.load_vy    = '0;
      bus.start      = 1'b0;
      bus.dt         = '0;
      bus.ax         = '0;
      bus.ay         = '0;
      bus.radius     = '0;
      bus.out_ready  = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_load_ready", 32'(bus.load_ready), 32'd1);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_coll_count", 32'(bus.coll_count), 32'd0);
      chk("rst_out_x", 32'(bus.out_x), 32'd0);
      rst = 1'b0;

      // integration: v = 0 + 1.0*0.5 , x = 0 + 0.5*1.0
      load(0, 16'd0, 16'd0, 16'd0, 16'd0);
      do_step(16'd2048, 16'd1024, 16'd0, 16'd0, -1, 0, 1'b0);
      chk("int_done_cyc", 32'(done_cyc), 32'(15 + WX));
      chk("int_first_valid", 32'(first_cyc), 32'(11 + WX));
      chk_bot(0, 16'd1024, 16'd0, 16'd1024, 16'd0, 1'b0);
      chk_bot(3, 16'd1024, 16'd0, 16'd1024, 16'd0, 1'b0);
      chk("int_coll_count", 32'(bus.coll_count), 32'd0);

      // head-on pair swap; bot3 loaded in the same cycle as start
      load(0, 16'd0, 16'd0, 16'd2048, 16'd0);
      load(1, 16'd300, 16'd0, 16'hF800, 16'd0);
      load(2, 16'd10000, 16'd10000, 16'd0, 16'd0);
      bus.load_valid = 1'b1;
      bus.load_idx   = 2'd3;
      bus.load_x     = 16'hD8F0;
      bus.load_y     = 16'hD8F0;
      bus.load_vx    = 16'd0;
      bus.load_vy    = 16'd0;
      do_step(16'd0, 16'd0, 16'd0, 16'd450, -1, 0, 1'b0);
      chk_bot(0, 16'd0, 16'd0, 16'hF800, 16'd0, 1'b1);
      chk_bot(1, 16'd300, 16'd0, 16'h0800, 16'd0, 1'b1);
      chk_bot(2, 16'd10000, 16'd10000, 16'd0, 16'd0, 1'b0);
`ifdef SWARM_WALL_BOUNCE_EN
      chk_bot(3, 16'd0, 16'd0, 16'd0, 16'd0, 1'b0);
`else
      chk_bot(3, 16'hD8F0, 16'hD8F0, 16'd0, 16'd0, 1'b0);
`endif
      chk("swap_coll_count", 32'(bus.coll_count), 32'd1);

      // three co-located bots chain swaps; bot3 at distance exactly radius
      load(0, 16'd0, 16'd0, 16'd1, 16'd10);
      load(1, 16'd0, 16'd0, 16'd2, 16'd20);
      load(2, 16'd0, 16'd0, 16'd3, 16'd30);
      load(3, 16'd3, 16'd4, 16'd7, 16'd70);
      do_step(16'd0, 16'd0, 16'd0, 16'd5, -1, 0, 1'b0);
      chk_bot(0, 16'd0, 16'd0, 16'd3, 16'd30, 1'b1);
      chk_bot(1, 16'd0, 16'd0, 16'd2, 16'd20, 1'b1);
      chk_bot(2, 16'd0, 16'd0, 16'd1, 16'd10, 1'b1);
      chk_bot(3, 16'd3, 16'd4, 16'd7, 16'd70, 1'b0);
      chk("chain_coll_count", 32'(bus.coll_count), 32'd3);

      // positive and negative saturation
      load(0, 16'd0, 16'd0, 16'h7000, 16'd0);
      load(1, 16'h8000, 16'd0, 16'h8000, 16'd0);
      load(2, 16'd0, 16'd0, 16'd0, 16'd0);
      load(3, 16'd0, 16'd0, 16'd0, 16'd0);
      do_step(16'd2048, 16'h7000, 16'd0, 16'd0, -1, 0, 1'b0);
`ifdef SWARM_WALL_BOUNCE_EN
      chk_bot(0, 16'h7800, 16'd0, 16'h8001, 16'd0, 1'b0);
      chk_bot(1, 16'd0, 16'd0, 16'h1000, 16'd0, 1'b0);
`else
      chk_bot(0, 16'h7FFF, 16'd0, 16'h7FFF, 16'd0, 1'b0);
      chk_bot(1, 16'h8000, 16'd0, 16'hF000, 16'd0, 1'b0);
`endif

      // backpressure on beat 2; ay=-1 with dt=1 floors to -1
      for (int i = 0; i < N; i++)
         load(i, 16'(100 * (i + 1)), 16'(1000 + i), 16'(16 + i), 16'(32 + i));
      do_step(16'd1, 16'd0, 16'hFFFF, 16'd0, 2, 5, 1'b0);
      chk("bp_held", 32'(held_ok), 32'd1);
      chk("bp_done_cyc", 32'(done_cyc), 32'(20 + WX));
      chk("bp_first_valid", 32'(first_cyc), 32'(11 + WX));
      for (int i = 0; i < N; i++)
         chk_bot(i, 16'(100 * (i + 1)), 16'(1000 + i), 16'(16 + i),
                 16'(31 + i), 1'b0);

      // load and start while busy are ignored
      load(0, 16'd500, 16'd0, 16'd0, 16'd0);
      do_step(16'd2048, 16'd2048, 16'd0, 16'd0, -1, 0, 1'b1);
      chk("busy_done_cyc", 32'(done_cyc), 32'(15 + WX));
      chk_bot(0, 16'd2548, 16'd0, 16'd2048, 16'd0, 1'b0);
      chk("busy_load_ready_after", 32'(bus.load_ready), 32'd1);

      // reset during EMIT aborts without done
      bus.dt     = '0;
      bus.ax     = '0;
      bus.ay     = '0;
      bus.radius = '0;
      bus.start  = 1'b1;
      for (int c = 1; c <= 12 + WX; c++) begin
         @(negedge clk);
         bus.start = 1'b0;
      end
      chk("rst_pre_valid", 32'(bus.out_valid), 32'd1);
      rst = 1'b1;
      #1;
      chk("rst_async_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_async_busy", 32'(bus.busy), 32'd0);
      seen_done = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (bus.done) seen_done = 1'b1;
      end
      rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (bus.done) seen_done = 1'b1;
      end
      chk("rst_no_done", 32'(seen_done), 32'd0);
      do_step(16'd0, 16'd0, 16'd0, 16'd0, -1, 0, 1'b0);
      for (int i = 0; i < N; i++)
         chk_bot(i, 16'd0, 16'd0, 16'd0, 16'd0, 1'b0);

`ifdef SWARM_WALL_BOUNCE_EN
      load(0, 16'h7700, 16'd0, 16'd2048, 16'd0);
      do_step(16'd2048, 16'd0, 16'd0, 16'd0, -1, 0, 1'b0);
      chk_bot(0, 16'h7800, 16'd0, 16'hF800, 16'd0, 1'b0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/swarm_integrator.md
# swarm_integrator

Parametrised, synthesizable N-bot time-step engine for the swarm simulator. It holds position and velocity state for `N_BOTS` bots in signed Q(W-FRAC).FRAC fixed point. On each `start` it runs one semi-implicit Euler integration step, then a pairwise collision pass that exchanges velocities, then streams every bot's new state out. It replaces the per-bot update / collision / velocity-selector handshake chain with one sequenced block that scales with bot count.

## Interface
- `N_BOTS`, 4, number of bots (2..16)
- `W`, 16, state word width, signed
- `FRAC`, 11, fractional bits (1.0 = 2048 at default)
- `ARENA_MAX`, 16'h7800, upper arena bound for x and y (wall feature only)

Ports:
- `clock`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-high
- `load_valid`  in  1  write one bot's state (honoured only when `load_ready`)
- `load_ready`  out  1  high in IDLE only
- `load_idx`  in  clog2(N_BOTS)  bot index to load
- `load_x`, `load_y`, `load_vx`, `load_vy`  in  W each  initial state
- `start`  in  1  one-cycle request to run one time step
- `dt`, `ax`, `ay`  in  W each  time step and acceleration, sampled at start
- `radius`  in  W  collision radius (unsigned magnitude), sampled at start
- `busy`  out  1  high from the cycle after start acceptance until done
- `out_valid`  out  1  result beat valid
- `out_ready`  in  1  downstream accepts beat
- `out_idx`  out  clog2(N_BOTS)  bot index of beat
- `out_x`, `out_y`, `out_vx`, `out_vy`  out  W each  updated state
- `out_coll`  out  1  bot was in at least one collision this step
- `done`  out  1  one-cycle pulse after the last beat is accepted
- `coll_count`  out  8  collision pairs detected in the last step, saturating at 255

## Operation
- FSM states: IDLE, UPDATE, COLLIDE, WALL (macro only), EMIT, DONE.
- **IDLE.** `load_ready`=1. A load writes the register file.
  - `start` latches `dt`/`ax`/`ay`/`radius`, clears per-bot coll flags and `coll_count`, then goes to UPDATE.
  - `load_valid` and `start` in the same cycle: the load is written first, and the step uses the loaded value.
- **UPDATE.** One bot per cycle, i = 0..N-1:
  - v' = sat(v + (a*dt >>> FRAC))
  - p' = sat(p + (v'*dt >>> FRAC))
  - Products are full 2W signed. `>>>` is arithmetic shift (floor). `sat` clamps to [-2^(W-1), 2^(W-1)-1].
- **COLLIDE.** One pair (i,j), i<j, per cycle in lexicographic order, P = N(N-1)/2 cycles.
  - dx, dy are computed at W+1 bits.
  - Collision if dx²+dy² < radius², compared at full 2W+3 precision with no shift.
  - On collision: swap (vx,vy) of i and j, set both coll flags, increment `coll_count` (saturating).
  - Later pairs see the swapped velocities.
- **EMIT.** Bot 0..N-1 in order. A beat is accepted when `out_valid` && `out_ready`. Outputs hold stable while stalled.
- **DONE.** `done`=1 for one cycle, then return to IDLE.
- Inputs during a step:
  - `start` while busy: ignored.
  - `load_valid` while busy: ignored (`load_ready`=0).
  - `dt`/`ax`/`ay`/`radius` changes after start: no effect.

## Timing
- Reset (async assert, sync release) brings:
  - FSM to IDLE.
  - All bot state and coll flags to 0.
  - `busy`, `out_valid`, `done` to 0; `coll_count` to 0; `out_*` to 0.
  - `load_ready` to 1.
- Reset mid-step aborts immediately. No `done` is issued.
- Start accepted in cycle 0:
  - UPDATE occupies cycles 1..N.
  - COLLIDE occupies cycles N+1..N+P.
  - The first `out_valid` is in cycle N+P+1.
  - With `out_ready` held at 1, the last beat is in cycle N+P+N and `done` is in cycle N+P+N+1.
- The WALL pass, when compiled in, adds N cycles between COLLIDE and EMIT.
- A beat is accepted when `out_valid` && `out_ready`. With `out_ready`=0 the FSM stalls indefinitely with no data loss.
- `busy` deasserts in the same cycle `done` pulses. `start` is accepted again in the next cycle.

## Configuration
- `SWARM_WALL_BOUNCE_EN`: when defined, a WALL state is compiled in. It runs one bot per cycle after COLLIDE:
  - If p<0: p=0 and negate that velocity.
  - If p>ARENA_MAX: p=ARENA_MAX and negate that velocity.
  - Negation saturates: -(-2^(W-1)) = 2^(W-1)-1.
- When undefined: no WALL state, latency as above without the extra N, and positions are only saturated.

## Test plan
- **Integration.** Defaults, bot0 x=0,vx=0, dt=2048, ax=1024, ay=0, radius=0 → bot0 out_vx=1024, out_x=1024, out_coll=0; `done` at cycle 4+6+4+1=15.
- **Collision swap.** bot0 (0,0) v(2048,0), bot1 (300,0) v(-2048,0), others far apart, dt=0, a=0, radius=450 → bot0 vx=-2048, bot1 vx=2048, both out_coll=1, coll_count=1.
- **Saturation.** vx=16'h7000, ax=16'h7000, dt=2048 → out_vx=16'h7FFF, out_x=16'h7FFF.
- **Backpressure.** Drop `out_ready` for 5 cycles on beat 2 → beat 2 data held stable, all 4 beats delivered in order, `done` delayed 5 cycles.
- **Busy and reset.** load_valid and start during UPDATE → ignored, state unchanged. Assert `reset` during EMIT → out_valid=0 immediately, no `done`, a subsequent read-back step shows all state 0.
- **Wall (macro defined).** x=16'h7700, vx=2048, dt=2048 → out_x=ARENA_MAX=16'h7800, out_vx=-2048.
